// File: rtl/seg7_pkg.sv
// Seven-segment glyph constants shared by the scan driver and its decoder.
// Segment order is a..g from bit 6 down to bit 0, active-low.
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [6:0] SEG_0 = 7'b0000001;
   localparam logic [6:0] SEG_1 = 7'b1001111;
   localparam logic [6:0] SEG_2 = 7'b0010010;
   localparam logic [6:0] SEG_3 = 7'b0000110;
   localparam logic [6:0] SEG_4 = 7'b1001100;
   localparam logic [6:0] SEG_5 = 7'b0100100;
   localparam logic [6:0] SEG_6 = 7'b0100000;
   localparam logic [6:0] SEG_7 = 7'b0001111;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0000100;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b1100000;
   localparam logic [6:0] SEG_C = 7'b0110001;
   localparam logic [6:0] SEG_D = 7'b1000010;
   localparam logic [6:0] SEG_E = 7'b0110000;
   localparam logic [6:0] SEG_F = 7'b0111000;

   function automatic logic [6:0] seg7_glyph(input logic [3:0] nibble);
      logic [6:0] g;
      case (nibble)
         4'h0:    g = SEG_0;
         4'h1:    g = SEG_1;
         4'h2:    g = SEG_2;
         4'h3:    g = SEG_3;
         4'h4:    g = SEG_4;
         4'h5:    g = SEG_5;
         4'h6:    g = SEG_6;
         4'h7:    g = SEG_7;
         4'h8:    g = SEG_8;
         4'h9:    g = SEG_9;
         4'hA:    g = SEG_A;
         4'hB:    g = SEG_B;
         4'hC:    g = SEG_C;
         4'hD:    g = SEG_D;
         4'hE:    g = SEG_E;
         default: g = SEG_F;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-glyph decoder; in BCD mode nibbles above 9 blank.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       hex_mode,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (hex_mode || (nibble <= 4'd9))
         seg = seg7_glyph(nibble);
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver with frame-synchronous load,
// leading-zero suppression, per-digit blink and ghost blanking.
module seg_scan_driver
   import seg7_pkg::*;
#(
   parameter int NDIGITS      = 8,
   parameter int SCAN_DIV     = 1000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic                   hex_mode,
   input  logic                   lzs,
   input  logic                   load,
   input  logic [4*NDIGITS-1:0]   data,
   input  logic [NDIGITS-1:0]     dp_in,
   input  logic [NDIGITS-1:0]     blink_mask,
   output logic [6:0]             seg,
   output logic                   dp_n,
   output logic [NDIGITS-1:0]     an_n,
   output logic                   pending,
   output logic                   frame_done
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [PW-1:0]          presc_reg;
   logic [IW-1:0]          idx_reg;
   logic [BW-1:0]          bcnt_reg;
   logic                   bphase_reg;
   logic                   frame_done_reg;

   logic [4*NDIGITS-1:0]   pend_data_reg;
   logic [NDIGITS-1:0]     pend_dp_reg;
   logic [NDIGITS-1:0]     pend_blink_reg;
   logic                   pending_reg;

   logic [4*NDIGITS-1:0]   disp_data_reg;
   logic [NDIGITS-1:0]     disp_dp_reg;
   logic [NDIGITS-1:0]     disp_blink_reg;

   logic [6:0]             seg_reg, seg_next;
   logic                   dp_n_reg, dp_n_next;
   logic [NDIGITS-1:0]     an_n_reg, an_n_next;

   logic                   slot_end;
   logic                   wrap;
   logic [3:0]             nib_arr [NDIGITS];
   logic [NDIGITS-1:0]     nib_zero;
   logic [NDIGITS-1:0]     supp_mask;
   logic [NDIGITS-1:0]     an_sel;
   logic [3:0]             cur_nib;
   logic [6:0]             dec_seg;

   assign slot_end = (presc_reg == PW'(SCAN_DIV - 1));
   assign wrap     = slot_end && (idx_reg == IW'(NDIGITS - 1));

   // Scan timing and blink phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_reg      <= '0;
         idx_reg        <= '0;
         bcnt_reg       <= '0;
         bphase_reg     <= 1'b0;
         frame_done_reg <= 1'b0;
      end else begin
         presc_reg      <= slot_end ? '0 : presc_reg + PW'(1);
         frame_done_reg <= wrap;
         if (slot_end)
            idx_reg <= wrap ? '0 : idx_reg + IW'(1);
         if (wrap) begin
            if (bcnt_reg == BW'(BLINK_FRAMES - 1)) begin
               bcnt_reg   <= '0;
               bphase_reg <= ~bphase_reg;
            end else begin
               bcnt_reg <= bcnt_reg + BW'(1);
            end
         end
      end
   end

   // Loads park in the pending set; the display only changes at a frame wrap,
   // and a load landing on the wrap cycle itself goes straight to the display.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_data_reg  <= '0;
         pend_dp_reg    <= '0;
         pend_blink_reg <= '0;
         pending_reg    <= 1'b0;
         disp_data_reg  <= '0;
         disp_dp_reg    <= '0;
         disp_blink_reg <= '0;
      end else if (wrap) begin
         pending_reg <= 1'b0;
         if (load) begin
            disp_data_reg  <= data;
            disp_dp_reg    <= dp_in;
            disp_blink_reg <= blink_mask;
         end else if (pending_reg) begin
            disp_data_reg  <= pend_data_reg;
            disp_dp_reg    <= pend_dp_reg;
            disp_blink_reg <= pend_blink_reg;
         end
      end else if (load) begin
         pend_data_reg  <= data;
         pend_dp_reg    <= dp_in;
         pend_blink_reg <= blink_mask;
         pending_reg    <= 1'b1;
      end
   end

   // A digit is suppressible when it and every more significant digit are zero.
   for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_digit
      assign nib_arr[gi]  = disp_data_reg[4*gi +: 4];
      assign nib_zero[gi] = (disp_data_reg[4*gi +: 4] == 4'h0);
      assign an_sel[gi]   = (idx_reg == IW'(gi));
      if (gi == 0) begin : g_lsd
         assign supp_mask[gi] = 1'b0;
      end else begin : g_upper
         assign supp_mask[gi] = &nib_zero[NDIGITS-1:gi];
      end
   end

   assign cur_nib = nib_arr[idx_reg];

   seg7_decode u_decode (
      .nibble   (cur_nib),
      .hex_mode (hex_mode),
      .seg      (dec_seg)
   );

   always_comb begin
      seg_next  = SEG_BLANK;
      dp_n_next = 1'b1;
      an_n_next = '1;
      if (en) begin
         if (presc_reg != '0)
            an_n_next = ~an_sel;
         if (!(bphase_reg && disp_blink_reg[idx_reg])) begin
            dp_n_next = ~disp_dp_reg[idx_reg];
            seg_next  = (lzs && supp_mask[idx_reg]) ? SEG_BLANK : dec_seg;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_reg  <= SEG_BLANK;
         dp_n_reg <= 1'b1;
         an_n_reg <= '1;
      end else begin
         seg_reg  <= seg_next;
         dp_n_reg <= dp_n_next;
         an_n_reg <= an_n_next;
      end
   end

   assign seg        = seg_reg;
   assign dp_n       = dp_n_reg;
   assign an_n       = an_n_reg;
   assign pending    = pending_reg;
   assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a frame-level reference model predicts
// every output cycle, a monitor pops and compares one expectation per cycle.
module tb_seg_scan_driver;

   localparam int ND = 4;
   localparam int SD = 4;
   localparam int BF = 2;
   localparam int FR = ND * SD;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          en = 1'b0;
   logic          hex_mode = 1'b0;
   logic          lzs = 1'b0;
   logic          load = 1'b0;
   logic [15:0]   data = '0;
   logic [3:0]    dp_in = '0;
   logic [3:0]    blink_mask = '0;
   logic [6:0]    seg;
   logic          dp_n;
   logic [3:0]    an_n;
   logic          pending;
   logic          frame_done;

   always #5 clk = ~clk;

   seg_scan_driver #(.NDIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .hex_mode   (hex_mode),
      .lzs        (lzs),
      .load       (load),
      .data       (data),
      .dp_in      (dp_in),
      .blink_mask (blink_mask),
      .seg        (seg),
      .dp_n       (dp_n),
      .an_n       (an_n),
      .pending    (pending),
      .frame_done (frame_done)
   );

   typedef struct {
      logic [6:0] seg;
      logic       dp_n;
      logic [3:0] an_n;
      logic       pending;
      logic       frame_done;
      logic       seg_care;
      int         t;
   } exp_t;

   exp_t q[$];
   int n_cmp = 0;
   int n_bad = 0;

   logic [6:0] glyph_tab [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   // Reference model: what the current frame displays, plus the last load seen this frame.
   int          t;
   logic [15:0] m_data;
   logic [3:0]  m_dp, m_bl;
   logic        have_fl;
   logic [15:0] fl_data;
   logic [3:0]  fl_dp, fl_bl;
   logic        cur_en, cur_hex, cur_lzs;

   task automatic model_reset();
      t = 0; m_data = '0; m_dp = '0; m_bl = '0;
      have_fl = 1'b0; fl_data = '0; fl_dp = '0; fl_bl = '0;
   endtask

   // Called just after a falling edge: drive one cycle of inputs, push the
   // expected output for the following rising edge, then wait a cycle.
   task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] dp,
                       input logic [3:0] bm);
      exp_t e;
      int cnt, dig, frame;
      logic [3:0] nib;
      logic upper0;
      if (t > 0 && t % FR == 0 && have_fl) begin
         m_data = fl_data; m_dp = fl_dp; m_bl = fl_bl; have_fl = 1'b0;
      end
      cnt = t % SD; dig = (t / SD) % ND; frame = t / FR;
      en = cur_en; hex_mode = cur_hex; lzs = cur_lzs;
      load = ld; data = d; dp_in = dp; blink_mask = bm;
      e.t = t;
      e.an_n = (!cur_en || cnt == 0) ? 4'hF : ~(4'b0001 << dig);
      e.seg_care = !cur_en || cnt != 0;
      e.seg = 7'b1111111;
      e.dp_n = 1'b1;
      if (cur_en && !(((frame / BF) % 2 == 1) && m_bl[dig])) begin
         nib = m_data[4*dig +: 4];
         upper0 = 1'b1;
         for (int k = dig; k < ND; k++)
            if (m_data[4*k +: 4] != 4'h0) upper0 = 1'b0;
         e.dp_n = ~m_dp[dig];
         if (cur_lzs && dig > 0 && upper0) e.seg = 7'b1111111;
         else if (!cur_hex && nib > 4'd9) e.seg = 7'b1111111;
         else e.seg = glyph_tab[nib];
      end
      if (ld) begin
         fl_data = d; fl_dp = dp; fl_bl = bm; have_fl = 1'b1;
      end
      e.frame_done = ((t + 1) % FR == 0);
      e.pending = ((t + 1) % FR == 0) ? 1'b0 : have_fl;
      q.push_back(e);
      t++;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, data, dp_in, blink_mask);
   endtask

   task automatic go_to(input int off);
      while (t % FR != off) idle(1);
   endtask

   exp_t me;
   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         me = q.pop_front();
         n_cmp++;
         if (an_n !== me.an_n || pending !== me.pending || frame_done !== me.frame_done ||
             (me.seg_care && (seg !== me.seg || dp_n !== me.dp_n))) begin
            n_bad++;
            $display("FAIL cycle t=%0d: got seg=%b dp_n=%b an_n=%b pending=%b frame_done=%b, want seg=%b dp_n=%b an_n=%b pending=%b frame_done=%b (seg checked=%b)",
                     me.t, seg, dp_n, an_n, pending, frame_done,
                     me.seg, me.dp_n, me.an_n, me.pending, me.frame_done, me.seg_care);
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      n_cmp++;
      if (seg !== 7'b1111111 || dp_n !== 1'b1 || an_n !== 4'hF ||
          pending !== 1'b0 || frame_done !== 1'b0) begin
         n_bad++;
         $display("FAIL %s: got seg=%b dp_n=%b an_n=%b pending=%b frame_done=%b, want blank/1/1111/0/0",
                  tag, seg, dp_n, an_n, pending, frame_done);
      end
   endtask

   initial begin
      model_reset();
      cur_en = 1'b1; cur_hex = 1'b1; cur_lzs = 1'b0;
      #1 rst_n = 1'b0;
      #1 check_reset_outputs("power_on_reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Basic scan of 1234.
      step(1'b1, 16'h1234, 4'b0000, 4'b0000);
      idle(3 * FR - 1);

      // BCD vs hex glyphs for 00AF.
      go_to(5);
      cur_hex = 1'b0;
      step(1'b1, 16'h00AF, 4'b0010, 4'b0000);
      idle(2 * FR);
      cur_hex = 1'b1;
      idle(2 * FR);

      // Leading-zero suppression of 0050.
      go_to(9);
      cur_lzs = 1'b1;
      step(1'b1, 16'h0050, 4'b1000, 4'b0000);
      idle(2 * FR);

      // Last load in a frame wins; a load on the wrap cycle transfers directly.
      go_to(3);
      step(1'b1, 16'h1111, 4'b0000, 4'b0000);
      idle(4);
      step(1'b1, 16'h2222, 4'b0101, 4'b0000);
      idle(2 * FR);
      go_to(FR - 1);
      step(1'b1, 16'h9876, 4'b0000, 4'b0000);
      idle(FR);

      // Blink digit 0.
      cur_lzs = 1'b0;
      step(1'b1, 16'h8888, 4'b0001, 4'b0001);
      idle(6 * FR);

      // Reset mid-slot with a load pending.
      go_to(6);
      step(1'b1, 16'h4321, 4'b0000, 4'b0000);
      idle(1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("mid_slot_reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      idle(2 * FR);

      // Randomized traffic.
      for (int i = 0; i < 40 * FR; i++) begin
         if ($urandom_range(0, 31) == 0) cur_en = ~cur_en;
         if ($urandom_range(0, 15) == 0) cur_hex = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 15) == 0) cur_lzs = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 9) == 0) begin
            logic [15:0] rd;
            rd = 16'($urandom);
            if ($urandom_range(0, 2) == 0) rd[15:8] = 8'h00;
            step(1'b1, rd, 4'($urandom), 4'($urandom));
         end else begin
            idle(1);
         end
      end
      cur_en = 1'b1;
      idle(FR);

      @(posedge clk);
      #2;
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: %0d expectations left, want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
